dispatch_rename: RTL and testbench
==================================

Name: dispatch_rename

Overview:
- Dispatch stage between the instruction fifo (ififo) and the ROB/IIQ/LSQ.
- Renames sources through an ARF-indexed rename table (arf_id -> {valid, rob_id}) and resolves operands from the ROB or the ARF.
- Fires a triple handshake: ROB always; IIQ for integer ops; LSQ for load/store ops.
- Updates the rename table on dispatch and on retire; clears it on retire redirect.

Parameters:
- ROB_N_ENTRIES, 16, ROB depth; rob_id width RW = log2(ROB_N_ENTRIES) = 4.
- ARF_N_ENTRIES, 32, architectural registers; arf_id width 5.
- REG_DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 32, pc width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ififo_valid  in  1  decoded instruction available
- ififo_ready  out  1  instruction consumed this cycle
- ififo_is_int / ififo_is_ls  in  1 each  route to IIQ / LSQ (exactly one set)
- ififo_src1_valid, ififo_src2_valid, ififo_dst_valid  in  1 each  operand used
- ififo_src1_arf_id, ififo_src2_arf_id, ififo_dst_arf_id  in  5 each
- ififo_pc  in  32  instruction pc
- dispatch_valid  out  1  to ROB enqueue
- dispatch_ready  in  1  ROB not full
- dispatch_rob_id  in  RW  ROB id allocated to this instruction
- dispatch_dst_valid / dispatch_dst_arf_id / dispatch_pc  out  1/5/32  ROB entry fields
- rob_id_src1, rob_id_src2  out  RW  ROB read addresses
- rob_reg_ready_src1/2  in  1; rob_reg_data_src1/2  in  32
- arf_rd_id_src1/2  out  5; arf_rd_data_src1/2  in  32  (combinational ARF read)
- iiq_enq_valid / iiq_enq_ready  out / in  1 each
- lsq_enq_valid / lsq_enq_ready  out / in  1 each
- src1_renamed/src1_ready/src1_rob_id/src1_data  out  1/1/RW/32  resolved operand (src2 likewise)
- dst_rob_id  out  RW  equals dispatch_rob_id
- retire, retire_rob_id, retire_arf_id  in  1/RW/5  from ROB
- retire_redirect_pc_valid  in  1  flush request

Behaviour:
- State:
  - rename table: 32 x {valid, rob_id}.
  - 2-state FSM: RUN, FLUSH.
- Reset: all valid bits 0, FSM=RUN. All outputs combinational off state: fire-related outputs 0 while rst.
- Fire condition: fire = RUN & ififo_valid & dispatch_ready & (is_int ? iiq_enq_ready : lsq_enq_ready).
  - ififo_ready = fire.
  - dispatch_valid = RUN & ififo_valid & downstream-ready (same as fire).
  - iiq_enq_valid = fire & is_int; lsq_enq_valid = fire & is_ls.
  - No valid depends on its own ready loop beyond the terms above.
- Operand resolve (combinational, per src; table read uses pre-edge state):
  - src unused or arf_id==0 -> renamed=0, ready=1, data=0.
  - table valid -> renamed=1, rob_id=table.rob_id, ready=rob_reg_ready, data=rob_reg_data.
  - else -> renamed=0, ready=1, data=arf_rd_data.
- Table update at edge:
  - On fire with dst_valid & dst!=0: table[dst] <= {1, dispatch_rob_id}.
  - On retire: if table[retire_arf_id].valid and its rob_id==retire_rob_id, clear valid.
  - Same arf both events same cycle: dispatch write wins.
  - src==dst of the same instruction reads the old mapping.
- Redirect: retire_redirect_pc_valid in RUN -> fire forced 0 that cycle; at edge all valid <= 0, FSM -> FLUSH. FLUSH: fire 0 for one cycle, then RUN.
- Redirect while in FLUSH re-enters FLUSH.
- rst mid-operation overrides everything next edge.
- x0 is never mapped.

Decomposition:
- Shared package: rob_id_t, arf_id_t, reg_data_t, addr_t; ROB_N_ENTRIES and ARF_N_ENTRIES constants; new struct dispatch_operand_t {renamed, ready, rob_id, data}.
- Natural sub-module: rename_table. 32 entries, 2 read ports, 1 dispatch write, 1 conditional retire clear, 1 flash clear.

Test Plan:
- Reset, then dispatch add x5<-x1,x2 with rob_id 3 and ARF x1=7, x2=9 -> src renamed=0, data 7/9; table[5]={1,3}.
- Next instr uses x5 with rob_reg_ready_src1=0 -> src1_renamed=1, rob_id=3, ready=0. Then set ready=1, data=42 -> ready=1, data=42.
- Dispatch_ready=0 or iiq_enq_ready=0 for int op -> ififo_ready=0, no table write. LSQ-ready=0 does not block int op.
- Dispatch x5 at rob 4, then retire rob 3 arf 5 -> table[5] stays {1,4}. Retire rob 4 -> cleared. Same-cycle dispatch x5@6 plus retire x5@4 -> {1,6}.
- Redirect pulse -> no fire that cycle and the next; all mappings invalid; third cycle fires normally.
- Dst=x0 and src=x0 -> no table write; src ready=1, data=0.

Source files
------------

// File: rtl/dispatch_rename_pkg.sv
// Shared types for the dispatch/rename stage: id widths, operand bundle and
// the operand-resolve helper used by both source ports.
package dispatch_rename_pkg;

  localparam int ROB_N_ENTRIES  = 16;
  localparam int ARF_N_ENTRIES  = 32;
  localparam int REG_DATA_WIDTH = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int RW             = $clog2(ROB_N_ENTRIES);
  localparam int AW             = $clog2(ARF_N_ENTRIES);

  typedef logic [RW-1:0]             rob_id_t;
  typedef logic [AW-1:0]             arf_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH-1:0]     addr_t;

  typedef struct packed {
    logic      renamed;
    logic      ready;
    rob_id_t   rob_id;
    reg_data_t data;
  } dispatch_operand_t;

  typedef enum logic {ST_RUN, ST_FLUSH} dispatch_state_e;

  function automatic dispatch_operand_t resolve_operand(
    input logic      used,
    input arf_id_t   arf_id,
    input logic      map_valid,
    input rob_id_t   map_rob_id,
    input logic      rob_ready,
    input reg_data_t rob_data,
    input reg_data_t arf_data
  );
    dispatch_operand_t op;
    op.renamed = 1'b0;
    op.ready   = 1'b1;
    op.rob_id  = map_rob_id;
    op.data    = '0;
    if (used && (arf_id != '0)) begin
      if (map_valid) begin
        op.renamed = 1'b1;
        op.ready   = rob_ready;
        op.data    = rob_data;
      end else begin
        op.data    = arf_data;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/dispatch_rename_table.sv
// ARF-indexed rename map: arf_id -> {valid, rob_id}, two async read ports,
// one dispatch write, one matching-retire clear and a flash clear.
module dispatch_rename_table
  import dispatch_rename_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flash_clr_i,
  input  logic    wr_en_i,
  input  arf_id_t wr_arf_id_i,
  input  rob_id_t wr_rob_id_i,
  input  logic    ret_en_i,
  input  arf_id_t ret_arf_id_i,
  input  rob_id_t ret_rob_id_i,
  input  arf_id_t rd1_arf_id_i,
  output logic    rd1_valid_o,
  output rob_id_t rd1_rob_id_o,
  input  arf_id_t rd2_arf_id_i,
  output logic    rd2_valid_o,
  output rob_id_t rd2_rob_id_o
);

  logic [ARF_N_ENTRIES-1:0] valid_q;
  logic [ARF_N_ENTRIES-1:0] valid_d;
  logic [ARF_N_ENTRIES-1:0] hit_wr;
  logic [ARF_N_ENTRIES-1:0] hit_ret;
  rob_id_t                  rob_q [ARF_N_ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ARF_N_ENTRIES; gi++) begin : g_entry
      assign hit_wr[gi]  = wr_en_i && (wr_arf_id_i == arf_id_t'(gi));
      // A retire only frees the map if no younger writer has taken the entry.
      assign hit_ret[gi] = ret_en_i && (ret_arf_id_i == arf_id_t'(gi)) &&
                           valid_q[gi] && (rob_q[gi] == ret_rob_id_i);
    end
  endgenerate

  // Dispatch write is OR'ed in after the retire clear so it wins on a collision.
  assign valid_d = (valid_q & ~hit_ret) | hit_wr;

  always_ff @(posedge clk) begin
    if (rst || flash_clr_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      rob_q[wr_arf_id_i] <= wr_rob_id_i;
    end
  end

  assign rd1_valid_o  = valid_q[rd1_arf_id_i];
  assign rd1_rob_id_o = rob_q[rd1_arf_id_i];
  assign rd2_valid_o  = valid_q[rd2_arf_id_i];
  assign rd2_rob_id_o = rob_q[rd2_arf_id_i];

endmodule

// File: rtl/dispatch_rename.sv
// Dispatch stage: renames sources, resolves operands from ROB/ARF and fires
// the ROB + IIQ/LSQ handshake; a retire redirect flushes the map for a cycle.
module dispatch_rename
  import dispatch_rename_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      ififo_valid,
  output logic      ififo_ready,
  input  logic      ififo_is_int,
  input  logic      ififo_is_ls,
  input  logic      ififo_src1_valid,
  input  logic      ififo_src2_valid,
  input  logic      ififo_dst_valid,
  input  arf_id_t   ififo_src1_arf_id,
  input  arf_id_t   ififo_src2_arf_id,
  input  arf_id_t   ififo_dst_arf_id,
  input  addr_t     ififo_pc,
  output logic      dispatch_valid,
  input  logic      dispatch_ready,
  input  rob_id_t   dispatch_rob_id,
  output logic      dispatch_dst_valid,
  output arf_id_t   dispatch_dst_arf_id,
  output addr_t     dispatch_pc,
  output rob_id_t   rob_id_src1,
  output rob_id_t   rob_id_src2,
  input  logic      rob_reg_ready_src1,
  input  logic      rob_reg_ready_src2,
  input  reg_data_t rob_reg_data_src1,
  input  reg_data_t rob_reg_data_src2,
  output arf_id_t   arf_rd_id_src1,
  output arf_id_t   arf_rd_id_src2,
  input  reg_data_t arf_rd_data_src1,
  input  reg_data_t arf_rd_data_src2,
  output logic      iiq_enq_valid,
  input  logic      iiq_enq_ready,
  output logic      lsq_enq_valid,
  input  logic      lsq_enq_ready,
  output logic      src1_renamed,
  output logic      src1_ready,
  output rob_id_t   src1_rob_id,
  output reg_data_t src1_data,
  output logic      src2_renamed,
  output logic      src2_ready,
  output rob_id_t   src2_rob_id,
  output reg_data_t src2_data,
  output rob_id_t   dst_rob_id,
  input  logic      retire,
  input  rob_id_t   retire_rob_id,
  input  arf_id_t   retire_arf_id,
  input  logic      retire_redirect_pc_valid
);

  dispatch_state_e   state_q, state_d;
  logic              run_ok, down_ready, fire, tbl_wr_en;
  logic              map1_valid, map2_valid;
  rob_id_t           map1_rob_id, map2_rob_id;
  dispatch_operand_t op1, op2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (retire_redirect_pc_valid) begin
      state_d = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      state_d = ST_RUN;
    end
  end

  assign run_ok     = !rst && (state_q == ST_RUN) && !retire_redirect_pc_valid;
  assign down_ready = ififo_is_int ? iiq_enq_ready : lsq_enq_ready;
  assign fire       = run_ok && ififo_valid && dispatch_ready && down_ready;
  // x0 is hardwired, so it never gets a mapping.
  assign tbl_wr_en  = fire && ififo_dst_valid && (ififo_dst_arf_id != '0);

  dispatch_rename_table u_table (
    .clk          (clk),
    .rst          (rst),
    .flash_clr_i  (retire_redirect_pc_valid),
    .wr_en_i      (tbl_wr_en),
    .wr_arf_id_i  (ififo_dst_arf_id),
    .wr_rob_id_i  (dispatch_rob_id),
    .ret_en_i     (retire),
    .ret_arf_id_i (retire_arf_id),
    .ret_rob_id_i (retire_rob_id),
    .rd1_arf_id_i (ififo_src1_arf_id),
    .rd1_valid_o  (map1_valid),
    .rd1_rob_id_o (map1_rob_id),
    .rd2_arf_id_i (ififo_src2_arf_id),
    .rd2_valid_o  (map2_valid),
    .rd2_rob_id_o (map2_rob_id)
  );

  assign op1 = resolve_operand(ififo_src1_valid, ififo_src1_arf_id, map1_valid, map1_rob_id,
                               rob_reg_ready_src1, rob_reg_data_src1, arf_rd_data_src1);
  assign op2 = resolve_operand(ififo_src2_valid, ififo_src2_arf_id, map2_valid, map2_rob_id,
                               rob_reg_ready_src2, rob_reg_data_src2, arf_rd_data_src2);

  assign ififo_ready         = fire;
  assign dispatch_valid      = fire;
  assign iiq_enq_valid       = fire && ififo_is_int;
  assign lsq_enq_valid       = fire && ififo_is_ls;
  assign dispatch_dst_valid  = ififo_dst_valid;
  assign dispatch_dst_arf_id = ififo_dst_arf_id;
  assign dispatch_pc         = ififo_pc;
  assign dst_rob_id          = dispatch_rob_id;

  assign rob_id_src1    = map1_rob_id;
  assign rob_id_src2    = map2_rob_id;
  assign arf_rd_id_src1 = ififo_src1_arf_id;
  assign arf_rd_id_src2 = ififo_src2_arf_id;

  assign src1_renamed = op1.renamed;
  assign src1_ready   = op1.ready;
  assign src1_rob_id  = op1.rob_id;
  assign src1_data    = op1.data;
  assign src2_renamed = op2.renamed;
  assign src2_ready   = op2.ready;
  assign src2_rob_id  = op2.rob_id;
  assign src2_data    = op2.data;

endmodule

// File: tb/tb_dispatch_rename.sv
// Directed bench for dispatch_rename: each stimulus cycle pushes its expected
// response into a queue that a negedge monitor pops and compares.
module tb_dispatch_rename;

  logic        clk = 1'b0;
  logic        rst;
  logic        ififo_valid, ififo_ready, ififo_is_int, ififo_is_ls;
  logic        ififo_src1_valid, ififo_src2_valid, ififo_dst_valid;
  logic [4:0]  ififo_src1_arf_id, ififo_src2_arf_id, ififo_dst_arf_id;
  logic [31:0] ififo_pc;
  logic        dispatch_valid, dispatch_ready;
  logic [3:0]  dispatch_rob_id;
  logic        dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [31:0] dispatch_pc;
  logic [3:0]  rob_id_src1, rob_id_src2;
  logic        rob_reg_ready_src1, rob_reg_ready_src2;
  logic [31:0] rob_reg_data_src1, rob_reg_data_src2;
  logic [4:0]  arf_rd_id_src1, arf_rd_id_src2;
  logic [31:0] arf_rd_data_src1, arf_rd_data_src2;
  logic        iiq_enq_valid, iiq_enq_ready, lsq_enq_valid, lsq_enq_ready;
  logic        src1_renamed, src1_ready, src2_renamed, src2_ready;
  logic [3:0]  src1_rob_id, src2_rob_id, dst_rob_id;
  logic [31:0] src1_data, src2_data;
  logic        retire;
  logic [3:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic        retire_redirect_pc_valid;

  logic [31:0] arf_mem [32];
  assign arf_rd_data_src1 = arf_mem[arf_rd_id_src1];
  assign arf_rd_data_src2 = arf_mem[arf_rd_id_src2];

  always #5 clk = ~clk;

  dispatch_rename dut (
    .clk(clk), .rst(rst),
    .ififo_valid(ififo_valid), .ififo_ready(ififo_ready),
    .ififo_is_int(ififo_is_int), .ififo_is_ls(ififo_is_ls),
    .ififo_src1_valid(ififo_src1_valid), .ififo_src2_valid(ififo_src2_valid),
    .ififo_dst_valid(ififo_dst_valid),
    .ififo_src1_arf_id(ififo_src1_arf_id), .ififo_src2_arf_id(ififo_src2_arf_id),
    .ififo_dst_arf_id(ififo_dst_arf_id), .ififo_pc(ififo_pc),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rob_id(dispatch_rob_id), .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_pc(dispatch_pc),
    .rob_id_src1(rob_id_src1), .rob_id_src2(rob_id_src2),
    .rob_reg_ready_src1(rob_reg_ready_src1), .rob_reg_ready_src2(rob_reg_ready_src2),
    .rob_reg_data_src1(rob_reg_data_src1), .rob_reg_data_src2(rob_reg_data_src2),
    .arf_rd_id_src1(arf_rd_id_src1), .arf_rd_id_src2(arf_rd_id_src2),
    .arf_rd_data_src1(arf_rd_data_src1), .arf_rd_data_src2(arf_rd_data_src2),
    .iiq_enq_valid(iiq_enq_valid), .iiq_enq_ready(iiq_enq_ready),
    .lsq_enq_valid(lsq_enq_valid), .lsq_enq_ready(lsq_enq_ready),
    .src1_renamed(src1_renamed), .src1_ready(src1_ready),
    .src1_rob_id(src1_rob_id), .src1_data(src1_data),
    .src2_renamed(src2_renamed), .src2_ready(src2_ready),
    .src2_rob_id(src2_rob_id), .src2_data(src2_data),
    .dst_rob_id(dst_rob_id),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_redirect_pc_valid(retire_redirect_pc_valid)
  );

  typedef struct {
    string       nm;
    logic        fire, iiq, lsq;
    logic        r1, rd1;
    logic [3:0]  id1;
    logic [31:0] d1;
    logic        r2, rd2;
    logic [3:0]  id2;
    logic [31:0] d2;
    logic [3:0]  dst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares the DUT's combinational response mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.nm, "ififo_ready", 32'(ififo_ready), 32'(e.fire));
      cmp(e.nm, "dispatch_valid", 32'(dispatch_valid), 32'(e.fire));
      cmp(e.nm, "iiq_enq_valid", 32'(iiq_enq_valid), 32'(e.iiq));
      cmp(e.nm, "lsq_enq_valid", 32'(lsq_enq_valid), 32'(e.lsq));
      cmp(e.nm, "src1_renamed", 32'(src1_renamed), 32'(e.r1));
      cmp(e.nm, "src1_ready", 32'(src1_ready), 32'(e.rd1));
      cmp(e.nm, "src1_data", src1_data, e.d1);
      if (e.r1) cmp(e.nm, "src1_rob_id", 32'(src1_rob_id), 32'(e.id1));
      cmp(e.nm, "src2_renamed", 32'(src2_renamed), 32'(e.r2));
      cmp(e.nm, "src2_ready", 32'(src2_ready), 32'(e.rd2));
      cmp(e.nm, "src2_data", src2_data, e.d2);
      if (e.r2) cmp(e.nm, "src2_rob_id", 32'(src2_rob_id), 32'(e.id2));
      cmp(e.nm, "dst_rob_id", 32'(dst_rob_id), 32'(e.dst));
      $display("txn %-14s fire=%0b iiq=%0b lsq=%0b s1=%0b/%0b/%0h/%0h s2=%0b/%0b/%0h/%0h",
               e.nm, ififo_ready, iiq_enq_valid, lsq_enq_valid,
               src1_renamed, src1_ready, src1_rob_id, src1_data,
               src2_renamed, src2_ready, src2_rob_id, src2_data);
    end
  end

  task automatic instr(input logic v, input logic is_int,
                       input logic s1v, input logic [4:0] s1,
                       input logic s2v, input logic [4:0] s2,
                       input logic dv, input logic [4:0] d, input logic [3:0] rid);
    ififo_valid = v;       ififo_is_int = is_int;  ififo_is_ls = !is_int;
    ififo_src1_valid = s1v; ififo_src1_arf_id = s1;
    ififo_src2_valid = s2v; ififo_src2_arf_id = s2;
    ififo_dst_valid = dv;  ififo_dst_arf_id = d;
    dispatch_rob_id = rid; ififo_pc = 32'h1000 + {28'd0, rid} * 4;
  endtask

  task automatic rdy(input logic dr, input logic ir, input logic lr);
    dispatch_ready = dr; iiq_enq_ready = ir; lsq_enq_ready = lr;
  endtask

  task automatic robv(input logic r1, input logic [31:0] d1, input logic r2, input logic [31:0] d2);
    rob_reg_ready_src1 = r1; rob_reg_data_src1 = d1;
    rob_reg_ready_src2 = r2; rob_reg_data_src2 = d2;
  endtask

  task automatic ret(input logic [3:0] rid, input logic [4:0] aid);
    retire = 1'b1; retire_rob_id = rid; retire_arf_id = aid;
  endtask

  // Push the expected response for the cycle just driven, then advance one clock.
  task automatic expect_cycle(input string nm, input logic f, input logic i, input logic l,
                              input logic r1, input logic rd1, input logic [3:0] id1, input logic [31:0] d1,
                              input logic r2, input logic rd2, input logic [3:0] id2, input logic [31:0] d2);
    exp_t e;
    e.nm = nm; e.fire = f; e.iiq = i; e.lsq = l;
    e.r1 = r1; e.rd1 = rd1; e.id1 = id1; e.d1 = d1;
    e.r2 = r2; e.rd2 = rd2; e.id2 = id2; e.d2 = d2;
    e.dst = dispatch_rob_id;
    exp_q.push_back(e);
    @(posedge clk); #1;
    retire = 1'b0;
    retire_redirect_pc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) arf_mem[i] = 32'd100 + 32'(i);
    arf_mem[0] = 32'hDEAD; arf_mem[1] = 32'd7; arf_mem[2] = 32'd9;
    rst = 1'b1; retire = 1'b0; retire_rob_id = '0; retire_arf_id = '0;
    retire_redirect_pc_valid = 1'b0;
    instr(1, 1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 4'd3); rdy(1, 1, 1); robv(0, 0, 0, 0);
    @(posedge clk); #1;
    expect_cycle("reset", 0,0,0, 0,1,0,7, 0,1,0,9);
    rst = 1'b0;
    expect_cycle("add_x5", 1,1,0, 0,1,0,7, 0,1,0,9);

    instr(1, 1, 1, 5'd5, 1, 5'd2, 1, 5'd6, 4'd4); rdy(0, 1, 1); robv(0, 0, 0, 0);
    expect_cycle("src_pending", 0,0,0, 1,0,3,0, 0,1,0,9);
    robv(1, 42, 0, 0); rdy(1, 0, 1);
    expect_cycle("iiq_block", 0,0,0, 1,1,3,42, 0,1,0,9);
    instr(0, 1, 1, 5'd6, 1, 5'd2, 1, 5'd6, 4'd4); robv(0, 0, 0, 0); rdy(1, 1, 1);
    expect_cycle("no_write", 0,0,0, 0,1,0,106, 0,1,0,9);
    instr(1, 1, 1, 5'd5, 1, 5'd2, 1, 5'd6, 4'd7); robv(1, 42, 0, 0); rdy(1, 1, 0);
    expect_cycle("lsq_not_block", 1,1,0, 1,1,3,42, 0,1,0,9);

    instr(1, 0, 1, 5'd6, 1, 5'd5, 1, 5'd5, 4'd4); rdy(1, 0, 1); robv(1, 55, 0, 0);
    expect_cycle("ls_src_eq_dst", 1,0,1, 1,1,7,55, 1,0,3,0);
    instr(0, 1, 1, 5'd5, 1, 5'd6, 0, 5'd0, 4'd0); rdy(1, 1, 1); robv(0, 0, 0, 0); ret(4'd3, 5'd5);
    expect_cycle("retire_stale", 0,0,0, 1,0,4,0, 1,0,7,0);
    instr(1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 4'd6); robv(1, 77, 0, 0); ret(4'd4, 5'd5);
    expect_cycle("disp_wins", 1,1,0, 1,1,4,77, 0,1,0,0);
    instr(0, 1, 1, 5'd5, 1, 5'd6, 0, 5'd0, 4'd0); robv(0, 0, 0, 0); ret(4'd6, 5'd5);
    expect_cycle("retire_match", 0,0,0, 1,0,6,0, 1,0,7,0);
    expect_cycle("cleared", 0,0,0, 0,1,0,105, 1,0,7,0);

    instr(1, 1, 1, 5'd1, 1, 5'd6, 1, 5'd7, 4'd8); retire_redirect_pc_valid = 1'b1;
    expect_cycle("redirect", 0,0,0, 0,1,0,7, 1,0,7,0);
    instr(1, 1, 1, 5'd6, 1, 5'd5, 1, 5'd7, 4'd8);
    expect_cycle("flush", 0,0,0, 0,1,0,106, 0,1,0,105);
    instr(1, 1, 1, 5'd6, 1, 5'd7, 1, 5'd7, 4'd8);
    expect_cycle("resume", 1,1,0, 0,1,0,106, 0,1,0,107);
    instr(0, 1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 4'd0);
    expect_cycle("x7_mapped", 0,0,0, 1,0,8,0, 0,1,0,0);

    instr(1, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 4'd9);
    expect_cycle("x0_ops", 1,1,0, 0,1,0,0, 0,1,0,0);

    instr(1, 1, 1, 5'd7, 0, 5'd0, 1, 5'd9, 4'd10); retire_redirect_pc_valid = 1'b1;
    expect_cycle("redir_a", 0,0,0, 1,0,8,0, 0,1,0,0);
    retire_redirect_pc_valid = 1'b1;
    expect_cycle("redir_in_flush", 0,0,0, 0,1,0,107, 0,1,0,0);
    expect_cycle("flush_again", 0,0,0, 0,1,0,107, 0,1,0,0);
    expect_cycle("redir_run", 1,1,0, 0,1,0,107, 0,1,0,0);

    instr(1, 1, 1, 5'd9, 0, 5'd0, 1, 5'd9, 4'd11); rst = 1'b1;
    expect_cycle("rst_mid", 0,0,0, 1,0,10,0, 0,1,0,0);
    rst = 1'b0;
    expect_cycle("after_rst", 1,1,0, 0,1,0,109, 0,1,0,0);

    ififo_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
